// File: rtl/zigzag_dec.sv
// zigzag_dec: inverse zigzag reorder buffer for the JPEG decode path.
// Coefficients arrive in zigzag scan order and leave in raster order through
// a ping-pong pair of 64-entry banks, sustaining 1 in + 1 out per cycle.
// Optional build macro ZIGZAG_DEC_EOB_EN: early end-of-block via in_eob, with
// a per-bank written mask so unwritten raster positions read back as zero.
module zigzag_dec #(
  parameter int COEF_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  input  logic              in_eob,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last
);

  // zigzag scan index -> raster position
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [5:0]        wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [1:0]        full_q, full_d;
  logic [COEF_W-1:0] mem_q [2][64];
  logic [5:0]        waddr;
  logic              wr_acc, wr_close, rd_beat, rd_last, eob_close;
  logic [COEF_W-1:0] rd_word;

  // in_ready is also held low while reset is asserted
  assign in_ready  = rst & ena & ~full_q[wptr_q];
  assign out_valid = ena & full_q[rptr_q];
  assign out_first = out_valid & (rcnt_q == 6'd0);
  assign out_last  = out_valid & (rcnt_q == 6'd63);

  assign waddr    = ZZ[wcnt_q];
  assign wr_acc   = in_valid & in_ready;
  assign wr_close = wr_acc & ((wcnt_q == 6'd63) | eob_close);
  assign rd_beat  = out_valid & out_ready;
  assign rd_last  = rd_beat & (rcnt_q == 6'd63);
  assign rd_word  = mem_q[rptr_q][rcnt_q];

`ifdef ZIGZAG_DEC_EOB_EN
  logic [1:0][63:0] mask_q;

  assign eob_close = in_eob;
  assign out_data  = mask_q[rptr_q][rcnt_q] ? rd_word : '0;

  // written mask: cleared when a bank is released, set on each accepted beat;
  // release and fill always target different banks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
    end else begin
      if (rd_last) mask_q[rptr_q] <= '0;
      if (wr_acc)  mask_q[wptr_q][waddr] <= 1'b1;
    end
  end
`else
  logic unused_eob;
  assign unused_eob = in_eob;
  assign eob_close  = 1'b0;
  assign out_data   = rd_word;
`endif

  // next-state for counters, pointers and bank flags
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    full_d = full_q;
    if (rd_beat) begin
      if (rd_last) begin
        rcnt_d         = 6'd0;
        rptr_d         = ~rptr_q;
        full_d[rptr_q] = 1'b0;
      end else begin
        rcnt_d = rcnt_q + 6'd1;
      end
    end
    if (wr_acc) begin
      if (wr_close) begin
        wcnt_d         = 6'd0;
        wptr_d         = ~wptr_q;
        full_d[wptr_q] = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 6'd1;
      end
    end
  end

  // control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      wcnt_q <= 6'd0;
      rcnt_q <= 6'd0;
      full_q <= 2'b00;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      full_q <= full_d;
    end
  end

  // bank storage, scattered to raster position on write; contents not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q][waddr] <= in_data;
  end

endmodule

// File: tb/tb_zigzag_dec.sv
// Bench for zigzag_dec: randomized blocks, scoreboard of expected raster
// beats built from a diagonal-walk zigzag model, decoupled output monitor.
module tb_zigzag_dec;
  localparam int W = 12;

  logic clk = 1'b0, rst = 1'b0, ena = 1'b0;
  logic in_valid = 1'b0, in_eob = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_first, out_last;
  logic [W-1:0] out_data;

  zigzag_dec #(.COEF_W(W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eob(in_eob),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         f;
    logic         l;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, beat_cnt = 0, first_cyc = -1, last_cyc = 0;
  int acc_cnt = 0, stall_cnt = 0;
  bit bp_rand = 1'b0;
  logic ov_at_close = 1'b0;
  int zz_ref [64];
  logic [W-1:0] blk [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference zigzag: walk the anti-diagonals, alternating direction
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end
    end
  endtask

  // expected raster stream for a block whose first n scan beats were written
  task automatic push_block(input int n);
    logic [W-1:0] ras [64];
    exp_t e;
    for (int r = 0; r < 64; r++) ras[r] = '0;
    for (int k = 0; k < n; k++) ras[zz_ref[k]] = blk[k];
    for (int r = 0; r < 64; r++) begin
      e.d = ras[r]; e.f = (r == 0); e.l = (r == 63);
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) if (bp_rand) begin #1; out_ready = ($urandom % 3) != 0; end

  // monitor: pop and compare on every output beat
  always @(negedge clk) begin
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_first", out_first, e.f);
        chk("out_last", out_last, e.l);
      end
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      beat_cnt++;
    end
  end

  // mode: 0 random data, 1 data=k, 2 caller-filled blk; eob_len>0 closes early
  task automatic send(input int nbeats, input int mode, input int eob_len, input bit gaps);
    int k = 0, sent = 0, guard = 0;
    bit fresh = 1'b1, cl;
    while (sent < nbeats) begin
      if (fresh) begin
        if (mode != 2) for (int i = 0; i < 64; i++) blk[i] = (mode == 1) ? W'(i) : W'($urandom);
        fresh = 1'b0;
      end
      in_valid = gaps ? (($urandom % 4) != 0) : 1'b1;
      in_data  = blk[k];
`ifdef ZIGZAG_DEC_EOB_EN
      in_eob = (eob_len > 0) && (k == eob_len - 1);
`else
      in_eob = 1'($urandom % 2);
`endif
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc_cnt++; sent++;
        cl = (k == 63);
`ifdef ZIGZAG_DEC_EOB_EN
        cl = cl || in_eob;
`endif
        if (cl) begin
          ov_at_close = out_valid;
          push_block(k + 1);
          k = 0; fresh = 1'b1;
        end else k++;
      end else if (in_valid) stall_cnt++;
      @(posedge clk); #1;
      guard++;
      if (guard > 20000) begin
        checks++; failures++;
        $display("FAIL send_timeout actual=%0d required=%0d", sent, nbeats);
        break;
      end
    end
    in_valid = 1'b0; in_eob = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 5000) begin @(posedge clk); #1; g++; end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int a, b, g;
    build_zz();
    rst = 1'b0; ena = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // single ramp block: latency and first beat
    beat_cnt = 0;
    send(64, 1, 0, 1'b0);
    chk("lat_ov_before", ov_at_close, 0);
    chk("lat_ov_after", out_valid, 1);
    chk("lat_first", out_first, 1);
    chk("lat_data0", out_data, 0);
    wait_drain();
    chk("single_beats", beat_cnt, 64);

    // four blocks back-to-back: no stalls, no output gaps
    beat_cnt = 0; first_cyc = -1; stall_cnt = 0;
    send(256, 0, 0, 1'b0);
    wait_drain();
    chk("b2b_beats", beat_cnt, 256);
    chk("b2b_span", last_cyc - first_cyc, 255);
    chk("b2b_stalls", stall_cnt, 0);

    // backpressure: both banks fill, third block waits
    out_ready = 1'b0; acc_cnt = 0;
    fork
      send(192, 0, 0, 1'b0);
      begin
        g = 0;
        while (acc_cnt < 128 && g < 2000) begin @(posedge clk); #1; g++; end
        repeat (10) @(posedge clk); #1;
        chk("bp_acc", acc_cnt, 128);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset mid-block with one bank full
    out_ready = 1'b0;
    send(94, 0, 0, 1'b0);
    chk("prerst_in_ready", in_ready, 1);
    chk("prerst_out_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1; beat_cnt = 0;
    send(64, 0, 0, 1'b0);
    wait_drain();
    repeat (5) @(posedge clk); #1;
    chk("postrst_beats", beat_cnt, 64);
    chk("postrst_out_valid", out_valid, 0);

    // clock enable low mid-output
    beat_cnt = 0; acc_cnt = 0;
    fork
      send(128, 0, 0, 1'b0);
      begin
        g = 0;
        while (beat_cnt < 20 && g < 2000) begin @(posedge clk); #1; g++; end
        ena = 1'b0; b = beat_cnt; a = acc_cnt;
        repeat (5) begin
          @(negedge clk);
          chk("ena_out_valid", out_valid, 0);
          chk("ena_in_ready", in_ready, 0);
        end
        chk("ena_beats_frozen", beat_cnt, b);
        chk("ena_acc_frozen", acc_cnt, a);
        @(posedge clk); #1;
        ena = 1'b1;
      end
    join
    wait_drain();
    chk("ena_beats", beat_cnt, 128);

`ifdef ZIGZAG_DEC_EOB_EN
    // early end-of-block: unwritten positions read as zero
    blk[0] = 12'd7; blk[1] = 12'hFFD; blk[2] = 12'd2;
    send(3, 2, 3, 1'b0);
    wait_drain();
    send(64, 0, 0, 1'b0);
    wait_drain();
`endif

    // random traffic with input gaps and output backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef ZIGZAG_DEC_EOB_EN
      b = $urandom_range(1, 64);
      send(b, 0, b, 1'b1);
`else
      send(64, 0, 0, 1'b1);
`endif
    end
    bp_rand = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
